// File: rtl/ads_sample_avg.sv
// ads_sample_avg: boxcar decimator for ADS868x conversion words.
// Averages 2**LOG2N signed samples and offers the result on a valid/ready port.
module ads_sample_avg #(
    parameter int LOG2N      = 4,
    parameter bit OFFSET_BIN = 1'b1
) (
    input  logic             clk_ref,
    input  logic             sys_rst,
    input  logic             en,
    input  logic             din_valid,
    input  logic [15:0]      din,
    input  logic             clr_ovr,
    output logic             dout_valid,
    output logic [15:0]      dout,
    input  logic             dout_ready,
    output logic             overrun,
    output logic [LOG2N-1:0] sample_cnt
);

    localparam int ACC_W = 16 + LOG2N;
    localparam logic [LOG2N-1:0] LAST = '1;
    localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

    logic                    dv_q;
    logic                    capture;
    logic                    last_sample;
    logic                    load;
    logic                    accept;
    logic signed [15:0]      s;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;
    logic [15:0]             avg;

    // One capture per rising edge of the level-qualified word strobe.
    assign capture     = din_valid & ~dv_q;
    assign last_sample = (sample_cnt == LAST);
    assign load        = capture & en & last_sample;
    assign accept      = dout_valid & dout_ready;

    assign s       = OFFSET_BIN ? {~din[15], din[14:0]} : din;
    assign acc_sum = acc + {{LOG2N{s[15]}}, s};
    // Dropping the low LOG2N bits is an arithmetic shift (floor).
    assign avg     = acc_sum[LOG2N +: 16];

    always_ff @(posedge clk_ref or posedge sys_rst) begin
        if (sys_rst) begin
            dv_q <= 1'b0;
        end else begin
            dv_q <= din_valid;
        end
    end

    always_ff @(posedge clk_ref or posedge sys_rst) begin
        if (sys_rst) begin
            acc        <= '0;
            sample_cnt <= '0;
        end else if (!en) begin
            acc        <= '0;
            sample_cnt <= '0;
        end else if (capture) begin
            if (last_sample) begin
                acc        <= '0;
                sample_cnt <= '0;
            end else begin
                acc        <= acc_sum;
                sample_cnt <= sample_cnt + ONE;
            end
        end
    end

    always_ff @(posedge clk_ref or posedge sys_rst) begin
        if (sys_rst) begin
            dout_valid <= 1'b0;
            dout       <= '0;
        end else if (load) begin
            dout_valid <= 1'b1;
            dout       <= avg;
        end else if (accept) begin
            dout_valid <= 1'b0;
        end
    end

    // A fresh overrun event takes priority over the clear.
    always_ff @(posedge clk_ref or posedge sys_rst) begin
        if (sys_rst) begin
            overrun <= 1'b0;
        end else if (load && dout_valid && !dout_ready) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ads_sample_avg.sv
// Bench for ads_sample_avg (LOG2N=2, offset binary) with a queue-based
// reference model: directed scenarios followed by randomized traffic.
module tb_ads_sample_avg;

    localparam int LOG2N = 2;
    localparam int N     = 4;

    logic             clk_ref = 1'b0;
    logic             sys_rst;
    logic             en;
    logic             din_valid;
    logic [15:0]      din;
    logic             clr_ovr;
    logic             dout_valid;
    logic [15:0]      dout;
    logic             dout_ready;
    logic             overrun;
    logic [LOG2N-1:0] sample_cnt;

    ads_sample_avg #(.LOG2N(LOG2N), .OFFSET_BIN(1'b1)) dut (
        .clk_ref    (clk_ref),
        .sys_rst    (sys_rst),
        .en         (en),
        .din_valid  (din_valid),
        .din        (din),
        .clr_ovr    (clr_ovr),
        .dout_valid (dout_valid),
        .dout       (dout),
        .dout_ready (dout_ready),
        .overrun    (overrun),
        .sample_cnt (sample_cnt)
    );

    always #5 clk_ref = ~clk_ref;

    int          n_vec = 0;
    int          n_err = 0;
    int          samples[$];
    logic        m_valid;
    logic [15:0] m_dout;
    logic        m_ovr;
    logic        m_prev_dv;
    int          rises;
    logic        last_dv;

    function automatic int to_signed(input logic [15:0] w);
        return int'(w) - 32768;
    endfunction

    function automatic int floor_div(input int a, input int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        samples.delete();
        m_valid   = 1'b0;
        m_dout    = '0;
        m_ovr     = 1'b0;
        m_prev_dv = 1'b0;
    endtask

    // Apply one clock edge to the model and the DUT, then compare.
    task automatic step();
        bit accept;
        bit new_res;
        int sum;
        logic [31:0] res;
        accept  = m_valid && dout_ready;
        new_res = 0;
        res     = '0;
        if (!en) begin
            samples.delete();
        end else if (din_valid && !m_prev_dv) begin
            samples.push_back(to_signed(din));
            if (samples.size() == N) begin
                sum = 0;
                foreach (samples[i]) sum += samples[i];
                res = 32'(floor_div(sum, N));
                samples.delete();
                new_res = 1;
            end
        end
        if (new_res && m_valid && !accept) m_ovr = 1'b1;
        else if (clr_ovr) m_ovr = 1'b0;
        if (new_res) begin
            m_dout  = res[15:0];
            m_valid = 1'b1;
        end else if (accept) begin
            m_valid = 1'b0;
        end
        m_prev_dv = din_valid;
        @(posedge clk_ref);
        #1;
        chk("dout_valid", 32'(dout_valid), 32'(m_valid));
        chk("dout", 32'(dout), 32'(m_dout));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("sample_cnt", 32'(sample_cnt), 32'(samples.size()));
        if (dout_valid && !last_dv) rises++;
        last_dv = dout_valid;
        @(negedge clk_ref);
    endtask

    task automatic send(input logic [15:0] w, input int hold);
        din       = w;
        din_valid = 1'b1;
        repeat (hold) step();
        din_valid = 1'b0;
        step();
    endtask

    initial begin
        sys_rst    = 1'b1;
        en         = 1'b1;
        din_valid  = 1'b0;
        din        = '0;
        clr_ovr    = 1'b0;
        dout_ready = 1'b1;
        rises      = 0;
        last_dv    = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_ref);
        sys_rst = 1'b0;
        #1;
        chk("rst_dout_valid", 32'(dout_valid), 32'h0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_cnt", 32'(sample_cnt), 32'h0);
        @(negedge clk_ref);

        // Midscale words average to zero.
        repeat (4) send(16'h8000, 2);
        chk("t1_dout", 32'(dout), 32'h0000);

        send(16'hFFFF, 1); send(16'hFFFF, 1);
        send(16'h0000, 1); send(16'h0000, 1);
        chk("t2_neg_floor", 32'(dout), 32'hFFFF);
        repeat (4) send(16'hFFFF, 1);
        chk("t2_max", 32'(dout), 32'h7FFF);
        repeat (4) send(16'h0000, 1);
        chk("t2_min", 32'(dout), 32'h8000);

        // Long level strobes: one sample per word.
        rises = 0;
        for (int i = 0; i < 8; i++) send(16'(16'h8000 + i * 100), 60);
        chk("t3_results", 32'(rises), 32'd2);

        // Back-pressure and overrun handling.
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'h9000, 1);
        for (int i = 0; i < 4; i++) send(16'hA000, 1);
        chk("t4_ovr", 32'(overrun), 32'h1);
        chk("t4_dout2", 32'(dout), 32'h2000);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        chk("t4_clr", 32'(overrun), 32'h0);
        for (int i = 0; i < 3; i++) send(16'h7000, 1);
        dout_ready = 1'b1;
        din        = 16'h7000;
        din_valid  = 1'b1;
        step();
        chk("t4_same_edge_valid", 32'(dout_valid), 32'h1);
        chk("t4_same_edge_ovr", 32'(overrun), 32'h0);
        din_valid = 1'b0;
        step();

        // Flush while disabled; pending result still drains.
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'hC000, 1);
        for (int i = 0; i < 3; i++) send(16'hF000, 1);
        en = 1'b0;
        step();
        chk("t5_flush_cnt", 32'(sample_cnt), 32'h0);
        dout_ready = 1'b1;
        step();
        chk("t5_accept_en0", 32'(dout_valid), 32'h0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) send(16'h8400, 1);
        chk("t5_result", 32'(dout), 32'h0400);

        // Asynchronous reset mid-average with a result pending.
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'h8100, 1);
        send(16'h9999, 1);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("t6_async_valid", 32'(dout_valid), 32'h0);
        chk("t6_async_dout", 32'(dout), 32'h0);
        chk("t6_async_cnt", 32'(sample_cnt), 32'h0);
        model_reset();
        @(negedge clk_ref);
        sys_rst    = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(16'h8010, 1);
        chk("t6_clean", 32'(dout), 32'h0010);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            din_valid  = ($urandom_range(0, 2) != 0) ? ~din_valid : din_valid;
            if (!din_valid) din = 16'($urandom);
            en         = ($urandom_range(0, 19) != 0);
            dout_ready = ($urandom_range(0, 2) != 0);
            clr_ovr    = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
